// File: rtl/pipe_pkg.sv
// Shared pipeline types: data/address widths, operand-fetch buffer states,
// the decoded-instruction record and the producer (bypass source) record.
package pipe_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } buf_state_t;

  typedef struct packed {
    logic [31:0]           pc;
    logic [ADDR_WIDTH-1:0] rs;
    logic [ADDR_WIDTH-1:0] rt;
    logic                  use_rs;
    logic                  use_rt;
    logic [ADDR_WIDTH-1:0] dest;
    logic                  dest_wen;
  } instr_t;

  typedef struct packed {
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  pending;
  } prod_t;
endpackage

// File: rtl/opfetch_bypass.sv
// Single-operand resolver: r0, EX, MEM, WB, then register file, first match wins.
// OPFETCH_FWD_EN enables the EX/MEM bypass; without it those matches interlock.
module opfetch_bypass
  import pipe_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] i_idx,
  input  logic                  i_use,
  input  prod_t                 i_ex,
  input  prod_t                 i_mem,
  input  logic                  i_wb_wen,
  input  logic [ADDR_WIDTH-1:0] i_wb_waddr,
  input  logic [DATA_WIDTH-1:0] i_wb_wdata,
  input  logic [DATA_WIDTH-1:0] i_rf_rdata,
  output logic [DATA_WIDTH-1:0] o_value,
  output logic                  o_hazard
);
  logic w_zero, w_ex_hit, w_mem_hit, w_wb_hit;

  assign w_zero    = (i_idx == '0);
  assign w_ex_hit  = i_ex.wen  && (i_ex.waddr  == i_idx);
  assign w_mem_hit = i_mem.wen && (i_mem.waddr == i_idx);
  assign w_wb_hit  = i_wb_wen  && (i_wb_waddr  == i_idx);

  always_comb begin
    o_value  = i_rf_rdata;
    o_hazard = 1'b0;
    if (w_zero) begin
      o_value = '0;
`ifdef OPFETCH_FWD_EN
    end else if (w_ex_hit) begin
      o_value  = i_ex.wdata;
      o_hazard = i_use && i_ex.pending;
    end else if (w_mem_hit) begin
      o_value  = i_mem.wdata;
      o_hazard = i_use && i_mem.pending;
`else
    end else if (w_ex_hit || w_mem_hit) begin
      o_hazard = i_use;
`endif
    end else if (w_wb_hit) begin
      // The register file only commits this write on the coming edge.
      o_value = i_wb_wdata;
    end
  end

`ifndef OPFETCH_FWD_EN
  logic w_unused_fwd;
  assign w_unused_fwd = ^{i_ex.wdata, i_ex.pending, i_mem.wdata, i_mem.pending};
`endif
endmodule

// File: rtl/id_operand_fetch.sv
// Decode-stage operand fetch: one-entry skid buffer, RF read, bypass/interlock,
// valid/ready issue to EX. Optional EX/MEM forwarding via OPFETCH_FWD_EN.
module id_operand_fetch #(
  parameter int DATA_WIDTH = pipe_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = pipe_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_pc,
  input  logic [ADDR_WIDTH-1:0] in_rs,
  input  logic [ADDR_WIDTH-1:0] in_rt,
  input  logic                  in_use_rs,
  input  logic                  in_use_rt,
  input  logic [ADDR_WIDTH-1:0] in_dest,
  input  logic                  in_dest_wen,
  output logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  input  logic                  ex_wen,
  input  logic [ADDR_WIDTH-1:0] ex_waddr,
  input  logic [DATA_WIDTH-1:0] ex_wdata,
  input  logic                  ex_pending,
  input  logic                  mem_wen,
  input  logic [ADDR_WIDTH-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_pending,
  input  logic                  wb_wen,
  input  logic [ADDR_WIDTH-1:0] wb_waddr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [DATA_WIDTH-1:0] out_src1,
  output logic [DATA_WIDTH-1:0] out_src2,
  output logic [ADDR_WIDTH-1:0] out_dest,
  output logic                  out_dest_wen,
  output logic [31:0]           stall_cnt
);
  pipe_pkg::buf_state_t r_state, w_state_nxt;
  pipe_pkg::instr_t     r_instr, w_in_instr;
  pipe_pkg::prod_t      w_ex, w_mem;
  logic [31:0]          r_stall_cnt;
  logic                 w_full, w_hazard1, w_hazard2, w_hazard, w_issue, w_accept;

  assign w_full     = (r_state == pipe_pkg::HOLD);
  assign w_in_instr = '{pc: in_pc, rs: in_rs, rt: in_rt, use_rs: in_use_rs,
                        use_rt: in_use_rt, dest: in_dest, dest_wen: in_dest_wen};
  assign w_ex  = '{wen: ex_wen,  waddr: ex_waddr,  wdata: ex_wdata,  pending: ex_pending};
  assign w_mem = '{wen: mem_wen, waddr: mem_waddr, wdata: mem_wdata, pending: mem_pending};

  assign rf_raddr1 = w_full ? r_instr.rs : '0;
  assign rf_raddr2 = w_full ? r_instr.rt : '0;

  opfetch_bypass u_byp1 (
    .i_idx(rf_raddr1), .i_use(w_full && r_instr.use_rs), .i_ex(w_ex), .i_mem(w_mem),
    .i_wb_wen(wb_wen), .i_wb_waddr(wb_waddr), .i_wb_wdata(wb_wdata),
    .i_rf_rdata(rf_rdata1), .o_value(out_src1), .o_hazard(w_hazard1)
  );

  opfetch_bypass u_byp2 (
    .i_idx(rf_raddr2), .i_use(w_full && r_instr.use_rt), .i_ex(w_ex), .i_mem(w_mem),
    .i_wb_wen(wb_wen), .i_wb_waddr(wb_waddr), .i_wb_wdata(wb_wdata),
    .i_rf_rdata(rf_rdata2), .o_value(out_src2), .o_hazard(w_hazard2)
  );

  assign w_hazard  = w_hazard1 || w_hazard2;
  assign out_valid = w_full && !w_hazard && !flush;
  assign w_issue   = out_valid && out_ready;
  assign in_ready  = !w_full || w_issue;
  // flush wins over both accept and issue on the edge.
  assign w_accept  = in_valid && in_ready && !flush;

  always_comb begin
    w_state_nxt = r_state;
    if (flush)         w_state_nxt = pipe_pkg::EMPTY;
    else if (w_accept) w_state_nxt = pipe_pkg::HOLD;
    else if (w_issue)  w_state_nxt = pipe_pkg::EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= pipe_pkg::EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_instr <= '0;
    else if (w_accept) r_instr <= w_in_instr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            r_stall_cnt <= '0;
    else if (w_full && w_hazard && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign out_pc       = r_instr.pc;
  assign out_dest     = r_instr.dest;
  assign out_dest_wen = r_instr.dest_wen;
  assign stall_cnt    = r_stall_cnt;
endmodule

// File: tb/tb_id_operand_fetch.sv
// Bench for id_operand_fetch: resolution vector table, multi-cycle sequences
// (stall, backpressure, flush, reset) and a scoreboarded back-to-back stream.
module tb_id_operand_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_use_rs, in_use_rt, in_dest_wen;
  logic [31:0] in_pc;
  logic [4:0]  in_rs, in_rt, in_dest, rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        ex_wen, ex_pending, mem_wen, mem_pending, wb_wen, flush;
  logic [4:0]  ex_waddr, mem_waddr, wb_waddr, out_dest;
  logic [31:0] ex_wdata, mem_wdata, wb_wdata;
  logic        out_valid, out_ready, out_dest_wen;
  logic [31:0] out_pc, out_src1, out_src2, stall_cnt;

  always #5 clk = ~clk;

  id_operand_fetch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs(in_rs), .in_rt(in_rt), .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
    .in_dest(in_dest), .in_dest_wen(in_dest_wen),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_pending(ex_pending),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_pending(mem_pending),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_src1(out_src1),
    .out_src2(out_src2), .out_dest(out_dest), .out_dest_wen(out_dest_wen), .stall_cnt(stall_cnt)
  );

  // Register file contents: r0=0, r3=0x11, every other rN = 0x1000+N.
  logic [31:0] rf [32];
  always_comb begin
    rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'd0 : rf[rf_raddr1];
    rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'd0 : rf[rf_raddr2];
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  rs, rt;
    logic        urs, urt;
    logic        exw;  logic [4:0] exa; logic [31:0] exd; logic exp_;
    logic        mw;   logic [4:0] ma;  logic [31:0] md;  logic mp;
    logic        ww;   logic [4:0] wa;  logic [31:0] wd;
    logic        ev;
    logic [31:0] e1, e2;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] rs, rt, input logic urs, urt,
                              input logic exw, input logic [4:0] exa, input logic [31:0] exd, input logic exp_,
                              input logic mw, input logic [4:0] ma, input logic [31:0] md, input logic mp,
                              input logic ww, input logic [4:0] wa, input logic [31:0] wd,
                              input logic ev, input logic [31:0] e1, e2);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.exw = exw; v.exa = exa; v.exd = exd; v.exp_ = exp_;
    v.mw = mw; v.ma = ma; v.md = md; v.mp = mp;
    v.ww = ww; v.wa = wa; v.wd = wd;
    v.ev = ev; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  typedef struct { logic [31:0] pc, s1, s2; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic mon_en = 1'b0;
  int   n_issued = 0;

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL stream.unexpected_issue: got pc %h, expected no issue", out_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("stream.pc", out_pc, mon_e.pc);
        chk("stream.src1", out_src1, mon_e.s1);
        chk("stream.src2", out_src2, mon_e.s2);
        n_issued++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clr_prod();
    ex_wen = 0; ex_waddr = 0; ex_wdata = 0; ex_pending = 0;
    mem_wen = 0; mem_waddr = 0; mem_wdata = 0; mem_pending = 0;
    wb_wen = 0; wb_waddr = 0; wb_wdata = 0;
  endtask

  task automatic load(input logic [31:0] pc, input logic [4:0] rs, rt, input logic urs, urt);
    in_valid = 1; in_pc = pc; in_rs = rs; in_rt = rt; in_use_rs = urs; in_use_rt = urt;
    in_dest = 5'd9; in_dest_wen = 1;
    step();
    in_valid = 0;
  endtask

  vec_t vt[11];
  logic [31:0] base;
  logic [4:0]  srs, srt;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'd0; rf[3] = 32'h11;
    rst = 1; in_valid = 0; in_pc = 0; in_rs = 0; in_rt = 0; in_use_rs = 0; in_use_rt = 0;
    in_dest = 0; in_dest_wen = 0; flush = 0; out_ready = 0;
    clr_prod();

    //         rs rt urs urt  exw exa exd      exp  mw ma md       mp  ww wa wd       ev e1       e2
    vt[0]  = mk(3, 4, 1, 1,   0, 0, 0,        0,   0, 0, 0,        0,  0, 0, 0,       1, 32'h11,  32'h1004);
`ifdef OPFETCH_FWD_EN
    vt[1]  = mk(3, 4, 1, 1,   1, 3, 32'hAA,   0,   1, 3, 32'hBB,   0,  1, 3, 32'hCC,  1, 32'hAA,  32'h1004);
    vt[2]  = mk(3, 4, 1, 1,   0, 0, 0,        0,   1, 3, 32'hBB,   0,  1, 3, 32'hCC,  1, 32'hBB,  32'h1004);
    vt[9]  = mk(3, 4, 1, 1,   1, 3, 32'hAA,   0,   1, 3, 32'hBB,   1,  0, 0, 0,       1, 32'hAA,  32'h1004);
`else
    vt[1]  = mk(3, 4, 1, 1,   1, 3, 32'hAA,   0,   1, 3, 32'hBB,   0,  1, 3, 32'hCC,  0, 0,       0);
    vt[2]  = mk(3, 4, 1, 1,   0, 0, 0,        0,   1, 3, 32'hBB,   0,  1, 3, 32'hCC,  0, 0,       0);
    vt[9]  = mk(3, 4, 1, 1,   1, 3, 32'hAA,   0,   1, 3, 32'hBB,   1,  0, 0, 0,       0, 0,       0);
`endif
    vt[3]  = mk(3, 4, 1, 1,   0, 0, 0,        0,   0, 0, 0,        0,  1, 3, 32'hCC,  1, 32'hCC,  32'h1004);
    vt[4]  = mk(0, 4, 1, 1,   1, 0, 32'hAA,   1,   0, 0, 0,        0,  0, 0, 0,       1, 32'h0,   32'h1004);
    vt[5]  = mk(3, 5, 1, 1,   1, 5, 32'h55,   1,   0, 0, 0,        0,  0, 0, 0,       0, 0,       0);
    vt[6]  = mk(3, 5, 1, 0,   1, 5, 32'h55,   1,   0, 0, 0,        0,  0, 0, 0,       1, 32'h11,  0);
    vt[7]  = mk(3, 4, 1, 1,   1, 3, 32'hAA,   1,   1, 3, 32'hBB,   0,  0, 0, 0,       0, 0,       0);
    vt[8]  = mk(3, 4, 1, 1,   1, 7, 32'h77,   1,   1, 3, 32'hBB,   1,  0, 0, 0,       0, 0,       0);
    vt[10] = mk(6, 6, 1, 1,   1, 8, 32'h88,   0,   0, 0, 0,        0,  1, 6, 32'h66,  1, 32'h66,  32'h66);

    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.stall_cnt", stall_cnt, 32'd0);
    chk("rst.out_pc", out_pc, 32'd0);
    chk("rst.rf_raddr1", 32'(rf_raddr1), 32'd0);
    @(posedge clk); #1; rst = 0;

    // Resolution vectors, each held with out_ready=0 and then flushed
    for (int i = 0; i < 11; i++) begin
      load(32'h200 + 32'(i) * 4, vt[i].rs, vt[i].rt, vt[i].urs, vt[i].urt);
      ex_wen = vt[i].exw; ex_waddr = vt[i].exa; ex_wdata = vt[i].exd; ex_pending = vt[i].exp_;
      mem_wen = vt[i].mw; mem_waddr = vt[i].ma; mem_wdata = vt[i].md; mem_pending = vt[i].mp;
      wb_wen = vt[i].ww; wb_waddr = vt[i].wa; wb_wdata = vt[i].wd;
      @(negedge clk);
      chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vt[i].ev));
      chk($sformatf("v%0d.rf_raddr1", i), 32'(rf_raddr1), 32'(vt[i].rs));
      chk($sformatf("v%0d.rf_raddr2", i), 32'(rf_raddr2), 32'(vt[i].rt));
      if (vt[i].ev) begin
        chk($sformatf("v%0d.src1", i), out_src1, vt[i].e1);
        if (vt[i].urt) chk($sformatf("v%0d.src2", i), out_src2, vt[i].e2);
      end
      @(posedge clk); #1;
      clr_prod(); flush = 1;
      step();
      flush = 0;
    end

    // Load-use stall on EX r5 for three cycles
    base = stall_cnt;
    out_ready = 1;
    load(32'h300, 5'd0, 5'd5, 1'b0, 1'b1);
    ex_wen = 1; ex_waddr = 5; ex_wdata = 32'h55; ex_pending = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall.c%0d.out_valid", k), 32'(out_valid), 32'd0);
      chk($sformatf("stall.c%0d.raddr2", k), 32'(rf_raddr2), 32'd5);
      @(posedge clk); #1;
    end
`ifdef OPFETCH_FWD_EN
    ex_pending = 0;
`else
    ex_wen = 0; ex_pending = 0; wb_wen = 1; wb_waddr = 5; wb_wdata = 32'h55;
`endif
    @(negedge clk);
    chk("stall.release.out_valid", 32'(out_valid), 32'd1);
    chk("stall.release.src2", out_src2, 32'h55);
    chk("stall.release.stall_cnt", stall_cnt, base + 32'd3);
    chk("stall.release.out_pc", out_pc, 32'h300);
    @(posedge clk); #1; clr_prod();
    @(negedge clk);
    chk("stall.after.out_valid", 32'(out_valid), 32'd0);
    chk("stall.after.in_ready", 32'(in_ready), 32'd1);

    // Backpressure with a second instruction waiting, then issue+reload
    @(posedge clk); #1; out_ready = 0;
    load(32'h100, 5'd3, 5'd4, 1'b1, 1'b1);
    in_valid = 1; in_pc = 32'h104; in_rs = 4; in_rt = 3; in_use_rs = 1; in_use_rt = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("bp.c%0d.in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp.c%0d.out_pc", k), out_pc, 32'h100);
      chk($sformatf("bp.c%0d.raddr1", k), 32'(rf_raddr1), 32'd3);
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp.in_ready", 32'(in_ready), 32'd1);
    chk("bp.a.src1", out_src1, 32'h11);
    chk("bp.a.dest", 32'(out_dest), 32'd9);
    @(posedge clk); #1; in_valid = 0;
    @(negedge clk);
    chk("bp.b.out_valid", 32'(out_valid), 32'd1);
    chk("bp.b.out_pc", out_pc, 32'h104);
    chk("bp.b.src1", out_src1, 32'h1004);
    chk("bp.b.src2", out_src2, 32'h11);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp.drain.out_valid", 32'(out_valid), 32'd0);

    // Flush together with a new in_valid
    @(posedge clk); #1; out_ready = 0;
    load(32'h500, 5'd3, 5'd0, 1'b1, 1'b0);
    in_valid = 1; in_pc = 32'h504; flush = 1;
    @(negedge clk);
    chk("flush.same.out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1; flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush.next.out_valid", 32'(out_valid), 32'd0);
    chk("flush.next.raddr1", 32'(rf_raddr1), 32'd0);
    chk("flush.next.in_ready", 32'(in_ready), 32'd1);

    // Back-to-back stream, checked by the scoreboard monitor
    @(posedge clk); #1; out_ready = 1; mon_en = 1;
    for (int k = 0; k < 8; k++) begin
      srs = 5'($urandom_range(1, 31));
      srt = 5'($urandom_range(1, 31));
      chk($sformatf("stream.k%0d.in_ready", k), 32'(in_ready), 32'd1);
      sb.push_back('{pc: 32'h600 + 32'(k) * 4, s1: rf[srs], s2: rf[srt]});
      in_valid = 1; in_pc = 32'h600 + 32'(k) * 4; in_rs = srs; in_rt = srt;
      in_use_rs = 1; in_use_rt = 1;
      step();
    end
    in_valid = 0;
    step();
    mon_en = 0;
    chk("stream.left_in_queue", 32'(sb.size()), 32'd0);
    chk("stream.issued", 32'(n_issued), 32'd8);

    // Asynchronous reset mid-HOLD while stalled
    out_ready = 0;
    load(32'h400, 5'd3, 5'd0, 1'b1, 1'b0);
    ex_wen = 1; ex_waddr = 3; ex_wdata = 32'hAA; ex_pending = 1;
    step();
    @(negedge clk);
    chk("rst2.pre.out_valid", 32'(out_valid), 32'd0);
    #2 rst = 1;
    #1;
    chk("rst2.out_valid", 32'(out_valid), 32'd0);
    chk("rst2.in_ready", 32'(in_ready), 32'd1);
    chk("rst2.stall_cnt", stall_cnt, 32'd0);
    chk("rst2.out_pc", out_pc, 32'd0);
    chk("rst2.out_dest_wen", 32'(out_dest_wen), 32'd0);
    @(posedge clk); #1; rst = 0; clr_prod();
    @(negedge clk);
    chk("rst2.next.out_valid", 32'(out_valid), 32'd0);
    chk("rst2.next.stall_cnt", stall_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
